// File: rtl/parking_session_ctrl_if.sv
// Bundle between the gate/keypad front end, the parking session controller and the
// billing/display logic.
//   slave  : controller side. It takes in the token, request, confirm, time and release
//            inputs, and drives the grant, deny, slot, occupancy and lock status outputs.
//   master : front-end/billing side. It is the mirror image of slave.
interface parking_session_ctrl_if #(
  parameter int unsigned TokenW = 3,
  parameter int unsigned TimeW  = 8,
  parameter int unsigned Slots  = 4
) ();
  localparam int unsigned SlotW = (Slots > 1) ? $clog2(Slots) : 1;

  logic [TokenW-1:0]  system_token;
  logic               request;
  logic               confirm;
  logic [TokenW-1:0]  user_token;
  logic [TimeW-1:0]   time_data;
  logic               release_valid;
  logic [SlotW-1:0]   release_slot;
  logic [TimeW/2-1:0] data_q;
  logic [TimeW/2-1:0] data_p;
  logic               grant;
  logic [SlotW-1:0]   slot_id;
  logic [Slots-1:0]   occupancy;
  logic               full;
  logic               deny;
  logic               locked;

  modport slave (
    input  system_token, request, confirm, user_token, time_data, release_valid, release_slot,
    output data_q, data_p, grant, slot_id, occupancy, full, deny, locked
  );

  modport master (
    output system_token, request, confirm, user_token, time_data, release_valid, release_slot,
    input  data_q, data_p, grant, slot_id, occupancy, full, deny, locked
  );
endinterface

// File: rtl/parking_session_ctrl.sv
// Multi-slot parking session controller.
// The controller authenticates a driver token and captures the entry time. It then
// allocates the lowest free slot and tracks slot occupancy. After MaxTries consecutive
// bad tokens it locks out for LockCyc cycles.
// Ports:
//   clk_i   rising-edge clock
//   rst_ni  asynchronous active-low reset
//   bus_io  slave modport of parking_session_ctrl_if. It carries these groups:
//           - token, request and confirm inputs
//           - time data and slot release inputs
//           - grant, deny, slot, occupancy, full and locked outputs
module parking_session_ctrl #(
  parameter int unsigned TokenW   = 3,
  parameter int unsigned TimeW    = 8,
  parameter int unsigned Slots    = 4,
  parameter int unsigned MaxTries = 3,
  parameter int unsigned LockCyc  = 16
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  parking_session_ctrl_if.slave bus_io
);
  localparam int unsigned SlotW = (Slots > 1) ? $clog2(Slots) : 1;
  localparam int unsigned HalfW = TimeW / 2;
  localparam int unsigned FailW = $clog2(MaxTries + 1);
  localparam int unsigned LockW = $clog2(LockCyc + 1);

  typedef enum logic [2:0] {StIdle, StAuth, StTime, StGrant, StLock} state_e;

  state_e             state_q, state_d;
  logic [FailW-1:0]   fail_q, fail_d, fail_inc;
  logic [LockW-1:0]   lock_q, lock_d;
  logic [Slots-1:0]   occ_q, occ_d;
  logic [SlotW-1:0]   slot_q, slot_d;
  logic [HalfW-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               deny_q, deny_d;

  logic [TokenW-1:0]  user_tok, sys_tok;
  logic               full;
  logic               alloc;
  logic [SlotW-1:0]   free_idx;
  logic [Slots-1:0]   rel_mask;
  logic [Slots-1:0]   alloc_mask;

  assign user_tok = bus_io.user_token;
  assign sys_tok  = bus_io.system_token;
  assign full     = &occ_q;

  // Lowest-numbered free slot in the pre-edge occupancy. The value is only used when !full.
  always_comb begin
    free_idx = '0;
    for (int i = int'(Slots) - 1; i >= 0; i--) begin
      if (!occ_q[i]) free_idx = SlotW'(i);
    end
  end

  // An out-of-range release slot matches no bit, so it has no effect.
  always_comb begin
    rel_mask = '0;
    for (int i = 0; i < int'(Slots); i++) begin
      if (bus_io.release_valid && (bus_io.release_slot == SlotW'(i))) rel_mask[i] = 1'b1;
    end
  end

  assign fail_inc = (fail_q == FailW'(MaxTries)) ? fail_q : fail_q + 1'b1;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      fail_q  <= '0;
      lock_q  <= '0;
      occ_q   <= '0;
      slot_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      deny_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
      lock_q  <= lock_d;
      occ_q   <= occ_d;
      slot_q  <= slot_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      deny_q  <= deny_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    lock_d  = lock_q;
    deny_d  = 1'b0;
    alloc   = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus_io.request) state_d = StAuth;
      end
      StAuth: begin
        if (!bus_io.request) begin
          state_d = StIdle;
        end else if (bus_io.confirm) begin
          if (user_tok == sys_tok) begin
            state_d = StTime;
            fail_d  = '0;
          end else begin
            deny_d = 1'b1;
            fail_d = fail_inc;
            if (fail_inc == FailW'(MaxTries)) begin
              state_d = StLock;
              lock_d  = '0;
            end
          end
        end
      end
      StTime: begin
        if (!bus_io.request) begin
          state_d = StIdle;
        end else if (bus_io.confirm) begin
          // Full is judged on pre-edge occupancy, so a same-cycle release does not help.
          if (full) begin
            deny_d  = 1'b1;
            state_d = StIdle;
          end else begin
            alloc   = 1'b1;
            state_d = StGrant;
          end
        end
      end
      StGrant: begin
        state_d = StIdle;
      end
      StLock: begin
        if (lock_q == LockW'(LockCyc - 1)) begin
          state_d = StIdle;
          lock_d  = '0;
          fail_d  = '0;
        end else begin
          lock_d = lock_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Occupancy and grant datapath. The allocated bit is free pre-edge, so it never clashes
  // with a bit being released.
  always_comb begin
    alloc_mask = alloc ? (Slots'(1) << free_idx) : '0;
    occ_d      = (occ_q & ~rel_mask) | alloc_mask;
    slot_d     = alloc ? free_idx : slot_q;
    hi_d       = alloc ? bus_io.time_data[TimeW-1:HalfW] : hi_q;
    lo_d       = alloc ? bus_io.time_data[HalfW-1:0] : lo_q;
  end

  // Outputs
  always_comb begin
    bus_io.grant     = (state_q == StGrant);
    bus_io.locked    = (state_q == StLock);
    bus_io.deny      = deny_q;
    bus_io.slot_id   = slot_q;
    bus_io.occupancy = occ_q;
    bus_io.full      = full;
    bus_io.data_q    = hi_q;
    bus_io.data_p    = lo_q;
  end
endmodule

// File: tb/tb_parking_session_ctrl.sv
// Scoreboard bench for parking_session_ctrl.
// Stimulus tasks update a transaction-level lot model and push the expected grant, deny and
// lock events. A monitor pops those events and compares them as the DUT raises its outputs.
module tb_parking_session_ctrl;
  localparam int unsigned TokenW   = 3;
  localparam int unsigned TimeW    = 8;
  localparam int unsigned Slots    = 4;
  localparam int unsigned MaxTries = 3;
  localparam int unsigned LockCyc  = 16;

  localparam int KGrant = 0;
  localparam int KDeny  = 1;
  localparam int KLock  = 2;

  typedef struct {
    int         kind;
    int         slot;
    logic [3:0] hi;
    logic [3:0] lo;
    logic [3:0] occ;
    logic       full;
  } exp_t;

  logic clk;
  logic rst_n;

  parking_session_ctrl_if #(.TokenW(TokenW), .TimeW(TimeW), .Slots(Slots)) bus ();

  parking_session_ctrl #(
    .TokenW  (TokenW),
    .TimeW   (TimeW),
    .Slots   (Slots),
    .MaxTries(MaxTries),
    .LockCyc (LockCyc)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_err    = 0;
  logic [3:0] m_occ;   // model: slot i occupied
  int         m_fails; // model: consecutive bad tokens

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lowest_free(input logic [3:0] occ);
    for (int i = 0; i < int'(Slots); i++) if (!occ[i]) return i;
    return -1;
  endfunction

  task automatic check_all_zero(input string name);
    check(name, {bus.grant, bus.deny, bus.locked, bus.full, bus.occupancy, bus.slot_id,
                 bus.data_q, bus.data_p}, 32'd0);
  endtask

  task automatic good_session(input logic [7:0] t, input bit do_rel, input int rel_slot);
    exp_t e;
    int   s;
    bus.request = 1'b1;
    tick();
    bus.confirm    = 1'b1;
    bus.user_token = bus.system_token;
    tick();
    m_fails       = 0;
    bus.time_data = t;
    if (do_rel) begin
      bus.release_valid = 1'b1;
      bus.release_slot  = 2'(rel_slot);
    end
    s = lowest_free(m_occ);
    if (do_rel) m_occ[rel_slot] = 1'b0;
    e.slot = s;
    e.hi   = t[7:4];
    e.lo   = t[3:0];
    if (s < 0) begin
      e.kind = KDeny;
    end else begin
      e.kind   = KGrant;
      m_occ[s] = 1'b1;
    end
    e.occ  = m_occ;
    e.full = &m_occ;
    exp_q.push_back(e);
    tick();
    bus.confirm       = 1'b0;
    bus.release_valid = 1'b0;
    bus.request       = 1'b0;
    tick();
  endtask

  task automatic lock_phase();
    int rs;
    for (int i = 0; i < int'(LockCyc) - 2; i++) begin
      bus.request       = 1'($urandom);
      bus.confirm       = 1'($urandom);
      bus.user_token    = bus.system_token;
      bus.release_valid = ($urandom_range(0, 3) == 0);
      rs                = $urandom_range(0, 3);
      bus.release_slot  = 2'(rs);
      if (bus.release_valid) m_occ[rs] = 1'b0;
      tick();
    end
    bus.release_valid = 1'b0;
    bus.request       = 1'b0;
    bus.confirm       = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic bad_session(input int k);
    exp_t e;
    bit   lk;
    lk = 1'b0;
    bus.request = 1'b1;
    tick();
    for (int j = 0; j < k; j++) begin
      bus.confirm    = 1'b1;
      bus.user_token = bus.system_token ^ 3'($urandom_range(1, 7));
      m_fails++;
      e.kind = KDeny;
      e.slot = 0;
      e.hi   = '0;
      e.lo   = '0;
      e.occ  = m_occ;
      e.full = &m_occ;
      exp_q.push_back(e);
      if (m_fails == int'(MaxTries)) begin
        e.kind = KLock;
        exp_q.push_back(e);
        lk      = 1'b1;
        m_fails = 0;
      end
      tick();
      if (lk) break;
    end
    bus.confirm = 1'b0;
    if (lk) begin
      lock_phase();
    end else begin
      bus.request = 1'b0;
      tick();
    end
  endtask

  task automatic abort_session(input bit in_time);
    bus.request = 1'b1;
    tick();
    if (in_time) begin
      bus.confirm    = 1'b1;
      bus.user_token = bus.system_token;
      tick();
      m_fails     = 0;
      bus.confirm = 1'b0;
    end
    bus.request = 1'b0;
    tick();
    tick();
  endtask

  task automatic release_txn(input int s);
    bus.release_valid = 1'b1;
    bus.release_slot  = 2'(s);
    tick();
    bus.release_valid = 1'b0;
    m_occ[s]          = 1'b0;
  endtask

  task automatic do_reset(input string name);
    bus.request       = 1'b0;
    bus.confirm       = 1'b0;
    bus.release_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_zero(name);
    tick();
    rst_n   = 1'b1;
    m_occ   = '0;
    m_fails = 0;
    tick();
  endtask

  task automatic reset_mid_time();
    bus.request = 1'b1;
    tick();
    bus.confirm    = 1'b1;
    bus.user_token = bus.system_token;
    tick();
    bus.confirm = 1'b0;
    do_reset("reset_mid_time");
  endtask

  // Monitor: compare every DUT event against the head of the scoreboard.
  initial begin
    exp_t e;
    int   lock_len;
    logic prev_locked;
    lock_len    = 0;
    prev_locked = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lock_len    = 0;
        prev_locked = 1'b0;
        continue;
      end
      if (bus.grant) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("grant_kind", KGrant, e.kind);
          check("grant_slot", bus.slot_id, e.slot);
          check("grant_data_q", bus.data_q, e.hi);
          check("grant_data_p", bus.data_p, e.lo);
          check("grant_occ", bus.occupancy, e.occ);
          check("grant_full", bus.full, e.full);
        end
      end
      if (bus.deny) begin
        if (exp_q.size() == 0) begin
          check("unexpected_deny", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("deny_kind", KDeny, e.kind);
          check("deny_occ", bus.occupancy, e.occ);
          check("deny_full", bus.full, e.full);
        end
      end
      if (bus.locked && !prev_locked) begin
        if (exp_q.size() == 0) begin
          check("unexpected_lock", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("lock_kind", KLock, e.kind);
        end
      end
      if (bus.locked) begin
        lock_len++;
      end else if (prev_locked) begin
        check("lock_len", lock_len, LockCyc);
        lock_len = 0;
      end
      prev_locked = bus.locked;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    rst_n             = 1'b0;
    bus.system_token  = 3'd5;
    bus.request       = 1'b0;
    bus.confirm       = 1'b0;
    bus.user_token    = '0;
    bus.time_data     = '0;
    bus.release_valid = 1'b0;
    bus.release_slot  = '0;
    m_occ             = '0;
    m_fails           = 0;
    #22 check_all_zero("reset_outputs");
    #8 rst_n = 1'b1;
    tick();

    // T1: first session takes slot 0, with the time split into its two halves
    good_session(8'hF2, 1'b0, 0);
    // T2: fill the lot, get a full deny, then free slot 2 and reuse it
    for (int i = 0; i < 3; i++) good_session(8'($urandom), 1'b0, 0);
    good_session(8'h5A, 1'b0, 0);
    release_txn(2);
    good_session(8'h3C, 1'b0, 0);
    // T3: three bad confirms in one session lead to lockout
    bad_session(3);
    // T4: a good token clears the fail count, so three more bad tokens are needed
    release_txn(1);
    bad_session(2);
    good_session(8'h77, 1'b0, 0);
    for (int i = 0; i < 3; i++) bad_session(1);
    // T5: a release in the same cycle as allocation does not free that slot for reuse
    do_reset("reset_t5");
    good_session(8'h11, 1'b0, 0);
    good_session(8'h22, 1'b0, 0);
    good_session(8'hA5, 1'b1, 0);
    // T6: aborts in AUTH and TIME, then a reset in the middle of TIME
    abort_session(1'b0);
    abort_session(1'b1);
    reset_mid_time();

    for (int n = 0; n < 250; n++) begin
      bus.system_token = 3'($urandom);
      op = $urandom_range(0, 19);
      if (op < 7) good_session(8'($urandom), ($urandom_range(0, 2) == 0), $urandom_range(0, 3));
      else if (op < 12) release_txn($urandom_range(0, 3));
      else if (op < 16) bad_session($urandom_range(1, 3));
      else if (op < 19) abort_session(1'($urandom));
      else reset_mid_time();
    end

    repeat (4) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
